time_unit_counter: RTL and testbench
====================================

# time_unit_counter

Parametrised modulo-N time-field counter for the real-time clock chain, generalising the fixed 0–59 seconds stage. It serves as the seconds, minutes or hours stage (MODULUS 60/60/24), counts up or down on a base tick and accepts a validated synchronous time-set load. It emits a registered carry/borrow pulse that drives the next stage's tick input, plus a lockstep BCD digit pair for display.

## Interface
- MODULUS, 60, count range 0..MODULUS-1; legal 2..100
- WIDTH, 7, width of binary count and load value; must satisfy 2**WIDTH >= MODULUS
- RESET_VALUE, 0, value of q_count after reset; must be < MODULUS
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high; sampled on posedge clk
- tick_in  input  1  advance enable, one-cycle pulse per count step
- count_down  input  1  0 = increment, 1 = decrement; sampled with tick_in
- load  input  1  time-set strobe
- load_value  input  WIDTH  value to load
- q_count  output  WIDTH  binary count
- q_tens  output  4  BCD tens digit of q_count
- q_ones  output  4  BCD ones digit of q_count
- tc_out  output  1  one-cycle carry (up) / borrow (down) pulse
- load_err  output  1  one-cycle pulse: load rejected, load_value >= MODULUS

## Operation
- Priority per edge: reset > load > tick_in.
- reset: q_count = RESET_VALUE, q_tens/q_ones = BCD(RESET_VALUE), tc_out = 0, load_err = 0.
- load with load_value < MODULUS: q_count = load_value, BCD digits updated to match, tc_out = 0.
- load with load_value >= MODULUS: count and digits hold, load_err = 1 for one cycle.
- Whenever load is high, tick_in is dropped, whether or not the load is accepted.
- tick_in, up: q_count < MODULUS-1 -> +1; q_count == MODULUS-1 -> 0 with tc_out = 1.
- tick_in, down: q_count > 0 -> -1; q_count == 0 -> MODULUS-1 with tc_out = 1.
- No tick and no load: state holds; tc_out = 0 and load_err = 0.
- All arithmetic is WIDTH bits. No intermediate value may exceed MODULUS-1.
- BCD digits are held in their own registers and never derived combinationally from q_count.
- Invariant on every cycle: q_tens*10 + q_ones == q_count.

## Timing
- Every output is registered; no combinational path from any input to any output.
- Latency from tick_in/load/reset to the new q_count, digits and tc_out/load_err is 1 cycle.
- tc_out is high in the cycle in which q_count shows the wrapped value (0 for up, MODULUS-1 for down).
- Cascading tc_out into the next stage's tick_in adds 1 cycle of delay per stage. This is accepted behaviour.
- Back-to-back ticks on consecutive cycles are legal; every tick produces a step.
- A reset in the same cycle as a wrap: reset wins and tc_out = 0.
- A load in the same cycle as a wrapping tick: load wins and tc_out = 0.

## Structure
- Shared package time_cnt_pkg holds:
  - function to_bcd(value) returning {tens, ones}
  - MOD_SECONDS = 60, MOD_MINUTES = 60, MOD_HOURS = 24
  - elaboration-check helper for MODULUS/WIDTH/RESET_VALUE legality
- Sub-module bcd_pair_counter owns the BCD digit registers:
  - inputs: inc, dec, load, load_tens, load_ones, max_tens, max_ones
  - ones wraps 9->0 with a tens step, and 0->9 with a tens borrow
  - at the max value the pair wraps to 00, and from 00 to the max value, according to the direction
- The top level owns the binary count, the range check, priority logic, tc_out and load_err.

## Test plan
- Reset, MODULUS=60: assert reset 2 cycles -> q_count=0, digits 0/0, tc_out=0. Apply 60 ticks -> q_count returns to 0, tc_out high exactly once, in the cycle q_count=0.
- Down wrap, MODULUS=24: load 0, then tick with count_down=1 -> q_count=23, tens=2, ones=3, tc_out=1 for one cycle.
- Load and tick together: q_count=10, load=1 with load_value=45 and tick_in=1 -> q_count=45 (tick dropped). Digits 4/5, tc_out=0.
- Illegal load, MODULUS=60: load_value=60 -> load_err=1 for one cycle, q_count unchanged. load_value=59 -> accepted, load_err=0.
- Cascade: three instances (60/60/24) chained via tc_out, starting from 23:59:59. One tick -> seconds 0 at +1 cycle, minutes 0 at +2 cycles, hours 0 at +3 cycles; each tc_out pulses once.
- Reset during wrap: q_count=59, tick_in and reset together -> q_count=RESET_VALUE, tc_out=0. Throughout a random tick/load/direction run, the BCD invariant is checked every cycle.

Source files
------------

// File: rtl/time_cnt_pkg.sv
// Shared definitions for the real-time clock counter chain: stage moduli,
// the BCD digit-pair type, binary-to-BCD conversion and parameter checking.
package time_cnt_pkg;

   localparam int MOD_SECONDS = 60;
   localparam int MOD_MINUTES = 60;
   localparam int MOD_HOURS   = 24;

   // Largest modulus whose top value still fits in two BCD digits.
   localparam int MOD_LIMIT   = 100;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd_pair_t;

   // Split a value below 100 into its decimal tens and ones digits.
   function automatic bcd_pair_t to_bcd(input logic [31:0] value);
      bcd_pair_t pair;
      pair.tens = 4'(value / 32'd10);
      pair.ones = 4'(value % 32'd10);
      return pair;
   endfunction

   // True when a stage's modulus, count width and reset value are usable
   // together: the modulus must fit two BCD digits, the count register must
   // hold every value up to modulus-1 and the reset value must be in range.
   function automatic bit params_legal(input int modulus,
                                       input int width,
                                       input int reset_value);
      return (modulus >= 2) && (modulus <= MOD_LIMIT)
          && (width >= 1) && (width <= 31)
          && ((longint'(1) << width) >= longint'(modulus))
          && (reset_value >= 0) && (reset_value < modulus);
   endfunction

endpackage

// File: rtl/time_unit_counter_if.sv
// Control and status bundle of one time-field counter stage. The master side
// issues ticks, direction and time-set loads; the slave side is the counter.
interface time_unit_counter_if #(
   parameter int WIDTH = 7
);

   logic             tick_in;
   logic             count_down;
   logic             load;
   logic [WIDTH-1:0] load_value;

   logic [WIDTH-1:0] q_count;
   logic [3:0]       q_tens;
   logic [3:0]       q_ones;
   logic             tc_out;
   logic             load_err;

   modport master (
      output tick_in,
      output count_down,
      output load,
      output load_value,
      input  q_count,
      input  q_tens,
      input  q_ones,
      input  tc_out,
      input  load_err
   );

   modport slave (
      input  tick_in,
      input  count_down,
      input  load,
      input  load_value,
      output q_count,
      output q_tens,
      output q_ones,
      output tc_out,
      output load_err
   );

endinterface

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD up/down counter that tracks the binary count of a stage in
// lockstep, so the display digits come straight from registers.
module bcd_pair_counter
   import time_cnt_pkg::*;
#(
   parameter logic [3:0] RESET_TENS = 4'd0,
   parameter logic [3:0] RESET_ONES = 4'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       dec,
   input  logic       load,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   input  logic [3:0] max_tens,
   input  logic [3:0] max_ones,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   logic [3:0] tens_q;
   logic [3:0] tens_d;
   logic [3:0] ones_q;
   logic [3:0] ones_d;
   logic       at_max;
   logic       at_zero;

   // Detect the two wrap points of the digit pair: the stage's top value and 00.
   always_comb begin
      at_max  = (tens_q == max_tens) && (ones_q == max_ones);
      at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
   end

   // Next digit pair: a load overrides stepping; stepping ripples the ones
   // digit into the tens digit and wraps the whole pair at either end.
   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      if (load) begin
         tens_d = load_tens;
         ones_d = load_ones;
      end else if (inc) begin
         if (at_max) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
         end else if (ones_q == 4'd9) begin
            tens_d = tens_q + 4'd1;
            ones_d = 4'd0;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end else if (dec) begin
         if (at_zero) begin
            tens_d = max_tens;
            ones_d = max_ones;
         end else if (ones_q == 4'd0) begin
            tens_d = tens_q - 4'd1;
            ones_d = 4'd9;
         end else begin
            ones_d = ones_q - 4'd1;
         end
      end
   end

   // Digit registers, returned to the stage's reset value on a synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         tens_q <= RESET_TENS;
         ones_q <= RESET_ONES;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign tens = tens_q;
   assign ones = ones_q;

endmodule

// File: rtl/time_unit_counter.sv
// One modulo-MODULUS stage of the real-time clock chain (seconds, minutes or
// hours). Counts up or down on tick_in, accepts range-checked time-set loads,
// and emits a registered carry/borrow pulse for the next stage plus BCD digits.
module time_unit_counter
   import time_cnt_pkg::*;
#(
   parameter int MODULUS     = 60,
   parameter int WIDTH       = 7,
   parameter int RESET_VALUE = 0
) (
   input logic                clk,
   input logic                reset,
   time_unit_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX_COUNT   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ZERO_COUNT  = '0;
   localparam logic [WIDTH-1:0] ONE_COUNT   = WIDTH'(1);
   localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH:0]   MODULUS_EXT = (WIDTH + 1)'(MODULUS);
   localparam bcd_pair_t        MAX_BCD     = to_bcd(32'(MODULUS - 1));
   localparam bcd_pair_t        RESET_BCD   = to_bcd(32'(RESET_VALUE));

   // Refuse to elaborate a stage whose parameters cannot work together.
   generate
      if (!params_legal(MODULUS, WIDTH, RESET_VALUE)) begin : g_bad_params
         $error("time_unit_counter: illegal MODULUS/WIDTH/RESET_VALUE combination");
      end
   endgenerate

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             tc_q;
   logic             tc_d;
   logic             load_err_q;
   logic             load_err_d;

   logic             load_in_range;
   logic             load_accept;
   logic             load_reject;
   logic             step_en;
   logic             step_up;
   logic             step_down;
   logic             at_max;
   logic             at_zero;
   bcd_pair_t        load_bcd;

   // Decode this cycle's action: a load always swallows a coincident tick,
   // even when the load itself is rejected as out of range.
   always_comb begin
      load_in_range = ({1'b0, bus.load_value} < MODULUS_EXT);
      load_accept   = bus.load && load_in_range;
      load_reject   = bus.load && !load_in_range;
      step_en       = bus.tick_in && !bus.load;
      step_up       = step_en && !bus.count_down;
      step_down     = step_en && bus.count_down;
      at_max        = (count_q == MAX_COUNT);
      at_zero       = (count_q == ZERO_COUNT);
      load_bcd      = to_bcd(32'(bus.load_value));
   end

   // Next binary count and status pulses; the count never leaves 0..MODULUS-1,
   // wrapping to the opposite end instead of passing through out-of-range values.
   always_comb begin
      count_d    = count_q;
      tc_d       = 1'b0;
      load_err_d = load_reject;
      if (load_accept) begin
         count_d = bus.load_value;
      end else if (step_up) begin
         if (at_max) begin
            count_d = ZERO_COUNT;
            tc_d    = 1'b1;
         end else begin
            count_d = count_q + ONE_COUNT;
         end
      end else if (step_down) begin
         if (at_zero) begin
            count_d = MAX_COUNT;
            tc_d    = 1'b1;
         end else begin
            count_d = count_q - ONE_COUNT;
         end
      end
   end

   // Binary count and pulse registers; reset clears any carry or load error.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q    <= RESET_COUNT;
         tc_q       <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         tc_q       <= tc_d;
         load_err_q <= load_err_d;
      end
   end

   // The display digits step with the same qualified controls as the binary count.
   bcd_pair_counter #(
      .RESET_TENS (RESET_BCD.tens),
      .RESET_ONES (RESET_BCD.ones)
   ) u_bcd (
      .clk       (clk),
      .reset     (reset),
      .inc       (step_up),
      .dec       (step_down),
      .load      (load_accept),
      .load_tens (load_bcd.tens),
      .load_ones (load_bcd.ones),
      .max_tens  (MAX_BCD.tens),
      .max_ones  (MAX_BCD.ones),
      .tens      (bus.q_tens),
      .ones      (bus.q_ones)
   );

   assign bus.q_count  = count_q;
   assign bus.tc_out   = tc_q;
   assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_time_unit_counter.sv
// Self-checking bench for time_unit_counter: a standalone seconds stage, a
// standalone hours stage with a non-zero reset value, and a cascaded
// seconds/minutes/hours chain. A modular-arithmetic reference model predicts
// the standalone stages every cycle.
module tb_time_unit_counter;
   import time_cnt_pkg::*;

   logic clk;
   logic reset;

   int check_count;
   int fail_count;

   int m60_cnt;
   bit m60_tc;
   bit m60_err;
   int m24_cnt;
   bit m24_tc;
   bit m24_err;

   time_unit_counter_if #(.WIDTH(7)) if60 ();
   time_unit_counter_if #(.WIDTH(7)) if24 ();
   time_unit_counter_if #(.WIDTH(7)) if_s ();
   time_unit_counter_if #(.WIDTH(7)) if_m ();
   time_unit_counter_if #(.WIDTH(7)) if_h ();

   time_unit_counter #(.MODULUS(MOD_SECONDS), .WIDTH(7), .RESET_VALUE(0)) dut60 (
      .clk(clk), .reset(reset), .bus(if60));
   time_unit_counter #(.MODULUS(MOD_HOURS), .WIDTH(7), .RESET_VALUE(12)) dut24 (
      .clk(clk), .reset(reset), .bus(if24));
   time_unit_counter #(.MODULUS(MOD_SECONDS), .WIDTH(7), .RESET_VALUE(0)) dut_sec (
      .clk(clk), .reset(reset), .bus(if_s));
   time_unit_counter #(.MODULUS(MOD_MINUTES), .WIDTH(7), .RESET_VALUE(0)) dut_min (
      .clk(clk), .reset(reset), .bus(if_m));
   time_unit_counter #(.MODULUS(MOD_HOURS), .WIDTH(7), .RESET_VALUE(0)) dut_hr (
      .clk(clk), .reset(reset), .bus(if_h));

   // Each stage's carry/borrow drives the next stage's tick.
   assign if_m.tick_in = if_s.tc_out;
   assign if_h.tick_in = if_m.tc_out;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stage: plain modular arithmetic on an integer count.
   function automatic void model_update(input int m, input int rv, input bit rst,
                                        input bit ld, input int lv, input bit tk,
                                        input bit dn, inout int cnt,
                                        output bit tc, output bit err);
      tc  = 1'b0;
      err = 1'b0;
      if (rst) begin
         cnt = rv;
      end else if (ld) begin
         if (lv < m) cnt = lv;
         else        err = 1'b1;
      end else if (tk) begin
         if (dn) begin
            tc  = (cnt == 0);
            cnt = (cnt + m - 1) % m;
         end else begin
            tc  = (cnt == m - 1);
            cnt = (cnt + 1) % m;
         end
      end
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
      check_count++;
      assert (obs === exp) else begin
         fail_count++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: capture the inputs the edge will see, advance, update models.
   task automatic step_clock();
      bit r, ld60, tk60, dn60, ld24, tk24, dn24;
      int lv60, lv24;
      r    = reset;
      ld60 = if60.load; tk60 = if60.tick_in; dn60 = if60.count_down;
      lv60 = int'(if60.load_value);
      ld24 = if24.load; tk24 = if24.tick_in; dn24 = if24.count_down;
      lv24 = int'(if24.load_value);
      @(posedge clk);
      #1;
      model_update(MOD_SECONDS, 0, r, ld60, lv60, tk60, dn60, m60_cnt, m60_tc, m60_err);
      model_update(MOD_HOURS, 12, r, ld24, lv24, tk24, dn24, m24_cnt, m24_tc, m24_err);
   endtask

   task automatic check_dut60(input string tag);
      check_output({tag, "/q60"},    32'(if60.q_count),  32'(m60_cnt));
      check_output({tag, "/tens60"}, 32'(if60.q_tens),   32'(m60_cnt / 10));
      check_output({tag, "/ones60"}, 32'(if60.q_ones),   32'(m60_cnt % 10));
      check_output({tag, "/tc60"},   32'(if60.tc_out),   32'(m60_tc));
      check_output({tag, "/err60"},  32'(if60.load_err), 32'(m60_err));
   endtask

   task automatic check_dut24(input string tag);
      check_output({tag, "/q24"},    32'(if24.q_count),  32'(m24_cnt));
      check_output({tag, "/tens24"}, 32'(if24.q_tens),   32'(m24_cnt / 10));
      check_output({tag, "/ones24"}, 32'(if24.q_ones),   32'(m24_cnt % 10));
      check_output({tag, "/tc24"},   32'(if24.tc_out),   32'(m24_tc));
      check_output({tag, "/err24"},  32'(if24.load_err), 32'(m24_err));
   endtask

   task automatic check_invariant(input string tag);
      check_output({tag, "/inv60"}, 32'(if60.q_tens) * 10 + 32'(if60.q_ones), 32'(if60.q_count));
      check_output({tag, "/inv24"}, 32'(if24.q_tens) * 10 + 32'(if24.q_ones), 32'(if24.q_count));
   endtask

   initial begin
      int tc_pulses;
      int tc_at_count;
      int s_pulses, m_pulses, h_pulses;

      check_count = 0;
      fail_count  = 0;
      m60_cnt = 0; m60_tc = 0; m60_err = 0;
      m24_cnt = 0; m24_tc = 0; m24_err = 0;

      reset = 1'b1;
      if60.tick_in = 0; if60.count_down = 0; if60.load = 0; if60.load_value = '0;
      if24.tick_in = 0; if24.count_down = 0; if24.load = 0; if24.load_value = '0;
      if_s.tick_in = 0; if_s.count_down = 0; if_s.load = 0; if_s.load_value = '0;
      if_m.count_down = 0; if_m.load = 0; if_m.load_value = '0;
      if_h.count_down = 0; if_h.load = 0; if_h.load_value = '0;

      $display("[TB] reset for two cycles");
      step_clock();
      step_clock();
      check_output("rst/q60",    32'(if60.q_count), 32'd0);
      check_output("rst/tens60", 32'(if60.q_tens),  32'd0);
      check_output("rst/ones60", 32'(if60.q_ones),  32'd0);
      check_output("rst/tc60",   32'(if60.tc_out),  32'd0);
      check_output("rst/err60",  32'(if60.load_err), 32'd0);
      check_output("rst/q24",    32'(if24.q_count), 32'd12);
      check_output("rst/tens24", 32'(if24.q_tens),  32'd1);
      check_output("rst/ones24", 32'(if24.q_ones),  32'd2);
      check_dut60("rst");
      check_dut24("rst");
      reset = 1'b0;

      $display("[TB] sixty consecutive up ticks on the seconds stage");
      tc_pulses   = 0;
      tc_at_count = -1;
      if60.tick_in = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step_clock();
         check_dut60("up60");
         if (if60.tc_out === 1'b1) begin
            tc_pulses++;
            tc_at_count = int'(if60.q_count);
         end
      end
      if60.tick_in = 1'b0;
      check_output("up60/final_q",   32'(if60.q_count), 32'd0);
      check_output("up60/tc_pulses", 32'(tc_pulses),    32'd1);
      check_output("up60/tc_at_q",   32'(tc_at_count),  32'd0);
      step_clock();
      check_output("up60/tc_drop", 32'(if60.tc_out), 32'd0);

      $display("[TB] down wrap on the hours stage");
      if24.load = 1'b1; if24.load_value = 7'd0;
      step_clock();
      check_dut24("dn24_load");
      if24.load = 1'b0; if24.count_down = 1'b1; if24.tick_in = 1'b1;
      step_clock();
      if24.tick_in = 1'b0;
      check_output("dn24/q",    32'(if24.q_count), 32'd23);
      check_output("dn24/tens", 32'(if24.q_tens),  32'd2);
      check_output("dn24/ones", 32'(if24.q_ones),  32'd3);
      check_output("dn24/tc",   32'(if24.tc_out),  32'd1);
      step_clock();
      check_output("dn24/tc_drop", 32'(if24.tc_out),  32'd0);
      check_output("dn24/hold",    32'(if24.q_count), 32'd23);
      if24.count_down = 1'b0;

      $display("[TB] load with coincident tick");
      if60.load = 1'b1; if60.load_value = 7'd10;
      step_clock();
      if60.load_value = 7'd45; if60.tick_in = 1'b1;
      step_clock();
      check_output("ldtk/q",    32'(if60.q_count), 32'd45);
      check_output("ldtk/tens", 32'(if60.q_tens),  32'd4);
      check_output("ldtk/ones", 32'(if60.q_ones),  32'd5);
      check_output("ldtk/tc",   32'(if60.tc_out),  32'd0);
      if60.tick_in = 1'b0; if60.load_value = 7'd59;
      step_clock();
      if60.load_value = 7'd7; if60.tick_in = 1'b1;
      step_clock();
      check_output("ldwrap/q",  32'(if60.q_count), 32'd7);
      check_output("ldwrap/tc", 32'(if60.tc_out),  32'd0);
      check_dut60("ldwrap");

      $display("[TB] out-of-range loads");
      if60.tick_in = 1'b1; if60.load_value = 7'd60;
      step_clock();
      check_output("ill60/err", 32'(if60.load_err), 32'd1);
      check_output("ill60/q",   32'(if60.q_count),  32'd7);
      check_output("ill60/ones", 32'(if60.q_ones),  32'd7);
      if60.tick_in = 1'b0; if60.load_value = 7'd127;
      step_clock();
      check_output("ill127/err", 32'(if60.load_err), 32'd1);
      check_output("ill127/q",   32'(if60.q_count),  32'd7);
      if60.load = 1'b0;
      step_clock();
      check_output("ill/err_drop", 32'(if60.load_err), 32'd0);
      if60.load = 1'b1; if60.load_value = 7'd59;
      step_clock();
      if60.load = 1'b0;
      check_output("ld59/err", 32'(if60.load_err), 32'd0);
      check_output("ld59/q",   32'(if60.q_count),  32'd59);
      check_dut60("ld59");

      $display("[TB] reset coinciding with a wrap");
      if60.tick_in = 1'b1; reset = 1'b1;
      step_clock();
      reset = 1'b0; if60.tick_in = 1'b0;
      check_output("rstwrap/q",  32'(if60.q_count), 32'd0);
      check_output("rstwrap/tc", 32'(if60.tc_out),  32'd0);
      check_dut60("rstwrap");
      check_dut24("rstwrap");

      $display("[TB] cascade from 23:59:59");
      if_s.load = 1'b1; if_s.load_value = 7'd59;
      if_m.load = 1'b1; if_m.load_value = 7'd59;
      if_h.load = 1'b1; if_h.load_value = 7'd23;
      step_clock();
      if_s.load = 1'b0; if_m.load = 1'b0; if_h.load = 1'b0;
      check_output("cas/s0", 32'(if_s.q_count), 32'd59);
      check_output("cas/m0", 32'(if_m.q_count), 32'd59);
      check_output("cas/h0", 32'(if_h.q_count), 32'd23);
      s_pulses = 0; m_pulses = 0; h_pulses = 0;
      if_s.tick_in = 1'b1;
      step_clock();
      if_s.tick_in = 1'b0;
      check_output("cas1/s",  32'(if_s.q_count), 32'd0);
      check_output("cas1/m",  32'(if_m.q_count), 32'd59);
      check_output("cas1/h",  32'(if_h.q_count), 32'd23);
      if (if_s.tc_out === 1'b1) s_pulses++;
      if (if_m.tc_out === 1'b1) m_pulses++;
      if (if_h.tc_out === 1'b1) h_pulses++;
      step_clock();
      check_output("cas2/m",    32'(if_m.q_count), 32'd0);
      check_output("cas2/mten", 32'(if_m.q_tens),  32'd0);
      check_output("cas2/h",    32'(if_h.q_count), 32'd23);
      if (if_s.tc_out === 1'b1) s_pulses++;
      if (if_m.tc_out === 1'b1) m_pulses++;
      if (if_h.tc_out === 1'b1) h_pulses++;
      step_clock();
      check_output("cas3/h",    32'(if_h.q_count), 32'd0);
      check_output("cas3/hdig", 32'({if_h.q_tens, if_h.q_ones}), 32'h00);
      check_output("cas3/htc",  32'(if_h.tc_out),  32'd1);
      if (if_s.tc_out === 1'b1) s_pulses++;
      if (if_m.tc_out === 1'b1) m_pulses++;
      if (if_h.tc_out === 1'b1) h_pulses++;
      for (int i = 0; i < 3; i++) begin
         step_clock();
         if (if_s.tc_out === 1'b1) s_pulses++;
         if (if_m.tc_out === 1'b1) m_pulses++;
         if (if_h.tc_out === 1'b1) h_pulses++;
      end
      check_output("cas/s_pulses", 32'(s_pulses), 32'd1);
      check_output("cas/m_pulses", 32'(m_pulses), 32'd1);
      check_output("cas/h_pulses", 32'(h_pulses), 32'd1);
      check_output("cas/final", 32'({if_h.q_count, if_m.q_count, if_s.q_count}), 32'd0);

      $display("[TB] random tick/load/direction run");
      for (int i = 0; i < 400; i++) begin
         reset            = ($urandom_range(0, 49) == 0);
         if60.tick_in     = ($urandom_range(0, 9) < 7);
         if60.count_down  = 1'($urandom_range(0, 1));
         if60.load        = ($urandom_range(0, 9) == 0);
         if60.load_value  = 7'($urandom_range(0, 127));
         if24.tick_in     = ($urandom_range(0, 9) < 7);
         if24.count_down  = 1'($urandom_range(0, 1));
         if24.load        = ($urandom_range(0, 9) == 0);
         if24.load_value  = 7'($urandom_range(0, 40));
         step_clock();
         check_dut60("rand");
         check_dut24("rand");
         check_invariant("rand");
      end
      reset = 1'b0;
      if60.tick_in = 0; if60.load = 0;
      if24.tick_in = 0; if24.load = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
      $finish;
   end

endmodule
